// File: rtl/game_pkg.sv
// Shared constants for the six-player highest-unique-number round controller.
package game_pkg;

  localparam int NPLAYERS = 6;

  localparam logic [2:0] OUT_NONE      = 3'd0;
  localparam logic [2:0] OUT_NO_UNIQUE = 3'd7;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    COLLECT = 4'd1,
    RESOLVE = 4'd2,
    RESULT  = 4'd3
  } state_e;

endpackage

// File: rtl/game_strobe_sync.sv
// Two-flop synchronizer for one player's strobe and 3-bit value, plus a
// single-cycle pulse on each rising edge of the synchronized strobe.
module strobe_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic       strb_i,
  input  logic [2:0] data_i,
  output logic [2:0] data_o,
  output logic       pulse_o
);

  // [0],[1]: synchronizer stages; [2]: previous synchronized sample for edge detect
  logic [2:0] strb_q;
  logic [2:0] data1_q;
  logic [2:0] data2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strb_q  <= '0;
      data1_q <= '0;
      data2_q <= '0;
    end else begin
      strb_q  <= {strb_q[1:0], strb_i};
      data1_q <= data_i;
      data2_q <= data1_q;
    end
  end

  assign pulse_o = strb_q[1] & ~strb_q[2];
  assign data_o  = data2_q;

endmodule

// File: rtl/game_fsm.sv
// Round controller: collects one value per player, closes the round when all
// six have submitted or after an idle timeout, and reports the highest unique value's owner.
module game_fsm
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] player1,
  input  logic [2:0] player2,
  input  logic [2:0] player3,
  input  logic [2:0] player4,
  input  logic [2:0] player5,
  input  logic [2:0] player6,
  input  logic [5:0] player_clk,
  output logic [2:0] out,
  output logic [3:0] state_out
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]          pin   [NPLAYERS];
  logic [2:0]          sdata [NPLAYERS];
  logic [NPLAYERS-1:0] ev;

  assign pin[0] = player1;
  assign pin[1] = player2;
  assign pin[2] = player3;
  assign pin[3] = player4;
  assign pin[4] = player5;
  assign pin[5] = player6;

  for (genvar g = 0; g < NPLAYERS; g++) begin : g_sync
    strobe_sync u_sync (
      .clk    (clk),
      .reset  (reset),
      .strb_i (player_clk[g]),
      .data_i (pin[g]),
      .data_o (sdata[g]),
      .pulse_o(ev[g])
    );
  end

  state_e              state_q, state_d;
  logic [2:0]          val_q [NPLAYERS];
  logic [2:0]          val_d [NPLAYERS];
  logic [NPLAYERS-1:0] sub_q, sub_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [2:0]          out_q, out_d;
  logic [NPLAYERS-1:0] cap;
  logic [2:0]          cnt [8];
  logic [2:0]          win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sub_q   <= '0;
      timer_q <= '0;
      out_q   <= OUT_NONE;
      for (int i = 0; i < NPLAYERS; i++) val_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      timer_q <= timer_d;
      out_q   <= out_d;
      for (int i = 0; i < NPLAYERS; i++) val_q[i] <= val_d[i];
    end
  end

  // Histogram of submitted values; ascending scan lets the highest unique value win.
  always_comb begin
    for (int v = 0; v < 8; v++) cnt[v] = '0;
    for (int i = 0; i < NPLAYERS; i++)
      if (sub_q[i]) cnt[val_q[i]] = cnt[val_q[i]] + 3'd1;
    win = OUT_NO_UNIQUE;
    for (int v = 0; v < 8; v++)
      if (cnt[v] == 3'd1)
        for (int i = 0; i < NPLAYERS; i++)
          if (sub_q[i] && val_q[i] == 3'(v)) win = 3'(i + 1);
  end

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    timer_d = timer_q;
    out_d   = out_q;
    cap     = '0;
    for (int i = 0; i < NPLAYERS; i++) val_d[i] = val_q[i];

    case (state_q)
      IDLE, RESULT: begin
        if (|ev) begin
          sub_d   = ev;
          timer_d = TMR_LOAD;
          state_d = COLLECT;
          for (int i = 0; i < NPLAYERS; i++) val_d[i] = ev[i] ? sdata[i] : 3'd0;
        end
      end
      COLLECT: begin
        cap   = ev & ~sub_q;
        sub_d = sub_q | cap;
        for (int i = 0; i < NPLAYERS; i++)
          if (cap[i]) val_d[i] = sdata[i];
        if (|cap)
          timer_d = TMR_LOAD;
        else if (timer_q != '0)
          timer_d = timer_q - TW'(1);
        if (&sub_d || (cap == '0 && timer_q == '0))
          state_d = RESOLVE;
      end
      RESOLVE: begin
        out_d   = win;
        state_d = RESULT;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out       = out_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_game_fsm.sv
// Directed and randomized bench for game_fsm against a round-level reference model.
module tb_game_fsm;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [17:0] pd = '0;
  logic [5:0]  player_clk = '0;
  logic [2:0]  out;
  logic [3:0]  state_out;

  int n_asrt = 0;
  int n_fail = 0;

  // Reference model: round-level view of the controller
  int          m_state;
  logic [2:0]  m_out;
  logic [5:0]  m_sub;
  logic [17:0] m_val;
  int          m_idle;
  logic [5:0]  sh0, sh1, sh2;
  logic [17:0] dh0, dh1;

  game_fsm #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .player1   (pd[2:0]),
    .player2   (pd[5:3]),
    .player3   (pd[8:6]),
    .player4   (pd[11:9]),
    .player5   (pd[14:12]),
    .player6   (pd[17:15]),
    .player_clk(player_clk),
    .out       (out),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] winner(input logic [5:0] sub, input logic [17:0] val);
    for (int v = 7; v >= 0; v--) begin
      int c   = 0;
      int who = 0;
      for (int i = 0; i < 6; i++)
        if (sub[i] && int'(val[3*i +: 3]) == v) begin
          c++;
          who = i + 1;
        end
      if (c == 1) return 3'(who);
    end
    return 3'd7;
  endfunction

  task automatic model_reset();
    m_state = 0; m_out = 3'd0; m_sub = '0; m_val = '0; m_idle = 0;
    sh0 = '0; sh1 = '0; sh2 = '0; dh0 = '0; dh1 = '0;
  endtask

  // An input rise sampled at edge e is seen as a submission at edge e+2.
  task automatic model_step(input logic [5:0] s, input logic [17:0] d);
    logic [5:0] evt, nc;
    evt = sh1 & ~sh2;
    case (m_state)
      0, 3: if (evt != 0) begin
        m_sub = evt;
        m_val = '0;
        for (int i = 0; i < 6; i++) if (evt[i]) m_val[3*i +: 3] = dh1[3*i +: 3];
        m_idle  = 0;
        m_state = 1;
      end
      1: begin
        nc = evt & ~m_sub;
        for (int i = 0; i < 6; i++) if (nc[i]) m_val[3*i +: 3] = dh1[3*i +: 3];
        m_sub = m_sub | nc;
        if (nc != 0) m_idle = 0;
        else m_idle++;
        if (m_sub == 6'h3f || m_idle >= T) m_state = 2;
      end
      2: begin
        m_out   = winner(m_sub, m_val);
        m_state = 3;
      end
      default: m_state = 0;
    endcase
    sh2 = sh1; sh1 = sh0; sh0 = s;
    dh1 = dh0; dh0 = d;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [5:0] s, input logic [17:0] d);
    @(negedge clk);
    player_clk = s;
    pd         = d;
    @(posedge clk);
    model_step(s, d);
    #1;
    chk("state", state_out, 4'(m_state));
    chk("out", {1'b0, out}, {1'b0, m_out});
  endtask

  task automatic idle(input int n);
    repeat (n) tick(6'd0, pd);
  endtask

  task automatic submit(input int pl, input logic [2:0] v);
    logic [17:0] nd;
    nd = pd;
    nd[3*pl +: 3] = v;
    tick(6'(1 << pl), nd);
    tick(6'd0, nd);
  endtask

  initial begin
    logic [5:0]  rs;
    logic [17:0] rd;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", state_out, 4'd0);
    chk("reset_out", {1'b0, out}, 4'd0);
    @(negedge clk);
    reset = 1'b0;

    // Latency, then timeout with a single player
    rd = '0;
    rd[2:0] = 3'd4;
    tick(6'b000001, rd);
    tick(6'd0, rd);
    chk("lat_edge2", state_out, 4'd0);
    tick(6'd0, rd);
    chk("lat_edge3", state_out, 4'd1);
    idle(17);
    chk("timeout_state", state_out, 4'd3);
    chk("timeout_out", {1'b0, out}, 4'd1);
    submit(1, 3'd2);
    tick(6'd0, pd);
    chk("newround_state", state_out, 4'd1);
    chk("newround_out_held", {1'b0, out}, 4'd1);
    idle(20);
    chk("p2_alone_out", {1'b0, out}, 4'd2);

    // Full round: 3,5,5,7,7,2
    submit(0, 3'd3);
    submit(1, 3'd5);
    submit(2, 3'd5);
    submit(3, 3'd7);
    submit(4, 3'd7);
    submit(5, 3'd2);
    tick(6'd0, pd);
    chk("full_resolve", state_out, 4'd2);
    idle(3);
    chk("full_out", {1'b0, out}, 4'd1);

    // Two players tie on 6
    rd = pd;
    rd[5:3] = 3'd6;
    rd[8:6] = 3'd6;
    tick(6'b000110, rd);
    tick(6'd0, rd);
    idle(22);
    chk("no_unique_out", {1'b0, out}, 4'd7);

    // Resubmission ignored
    submit(3, 3'd1);
    idle(3);
    submit(3, 3'd7);
    submit(4, 3'd3);
    idle(25);
    chk("resubmit_out", {1'b0, out}, 4'd5);

    // Event landing in RESOLVE is dropped
    submit(0, 3'd4);
    idle(15);
    submit(1, 3'd6);
    idle(4);
    chk("drop_state", state_out, 4'd3);
    chk("drop_out", {1'b0, out}, 4'd1);

    // Asynchronous reset mid-COLLECT
    submit(2, 3'd5);
    tick(6'd0, pd);
    chk("pre_reset_state", state_out, 4'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_reset_state", state_out, 4'd0);
    chk("async_reset_out", {1'b0, out}, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(5);
    chk("post_reset_state", state_out, 4'd0);

    // Randomized strobes and values
    for (int k = 0; k < 400; k++) begin
      for (int b = 0; b < 6; b++) rs[b] = ($urandom_range(0, 3) == 0);
      rd = 18'($urandom);
      tick(rs, rd);
    end
    idle(25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
